// File: rtl/register_file_pkg.sv
// Shared types and helpers for the multi-port register file: default widths,
// the write-port request record and the byte-lane merge used by every write path.
package register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_REG_COUNT  = 32;
  localparam int DEFAULT_READ_PORTS = 2;

  // Requests are carried at a fixed maximum width so one record type serves any instance.
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;
  localparam int MAX_ADDR_WIDTH = 16;

  typedef struct packed {
    logic                      enabled;
    logic [MAX_ADDR_WIDTH-1:0] address;
    logic [MAX_STRB_WIDTH-1:0] strobe;
    logic [MAX_DATA_WIDTH-1:0] data;
  } write_req_t;

  function automatic logic [MAX_DATA_WIDTH-1:0] merge_bytes(
    input logic [MAX_DATA_WIDTH-1:0] old_value,
    input logic [MAX_DATA_WIDTH-1:0] new_value,
    input logic [MAX_STRB_WIDTH-1:0] strobe
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_value;
    for (int b = 0; b < MAX_STRB_WIDTH; b++) begin
      if (strobe[b]) begin
        merged[b*8 +: 8] = new_value[b*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/register_file_write_merge.sv
// Next value and write-hit of one register given both write ports; port 1 is applied
// after port 0 so it wins on lanes both ports strobe.
module register_file_write_merge
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = 5
)(
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0] stored,
  input  write_req_t            port0,
  input  write_req_t            port1,
  output logic [DATA_WIDTH-1:0] next_value,
  output logic                  hit
);

  logic [MAX_ADDR_WIDTH-1:0] index_ext;
  logic                      hit0;
  logic                      hit1;
  logic [MAX_DATA_WIDTH-1:0] stored_ext;
  logic [MAX_DATA_WIDTH-1:0] stage0;
  logic [MAX_DATA_WIDTH-1:0] stage1;
  logic                      unused_stage;

  assign index_ext  = MAX_ADDR_WIDTH'(index);
  assign stored_ext = MAX_DATA_WIDTH'(stored);
  assign hit0 = port0.enabled && (port0.address == index_ext);
  assign hit1 = port1.enabled && (port1.address == index_ext);

  assign stage0 = hit0 ? merge_bytes(stored_ext, port0.data, port0.strobe) : stored_ext;
  assign stage1 = hit1 ? merge_bytes(stage0, port1.data, port1.strobe) : stage0;

  assign next_value   = stage1[DATA_WIDTH-1:0];
  assign hit          = hit0 || hit1;
  // Padding lanes above DATA_WIDTH are never looked at.
  assign unused_stage = ^stage1;

endmodule

// File: rtl/multi_port_register_file.sv
// Architectural register file: combinational read ports with optional write bypass,
// two byte-strobed write ports and a per-register pending scoreboard.
module multi_port_register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int REG_COUNT  = DEFAULT_REG_COUNT,
  parameter int READ_PORTS = DEFAULT_READ_PORTS,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  localparam int ADDR_WIDTH = $clog2(REG_COUNT),
  localparam int STRB_WIDTH = DATA_WIDTH / 8
)(
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]            read_pending,
  input  logic [1:0]                       write_enabled,
  input  logic [2*ADDR_WIDTH-1:0]          write_address,
  input  logic [2*STRB_WIDTH-1:0]          write_strobe,
  input  logic [2*DATA_WIDTH-1:0]          write_data,
  input  logic                             pending_set_enabled,
  input  logic [ADDR_WIDTH-1:0]            pending_set_address
);

  write_req_t            requests    [2];
  logic [DATA_WIDTH-1:0] regs_reg    [REG_COUNT];
  logic                  pending_reg [REG_COUNT];

  genvar gi;

  // Gating with reset_n keeps writes out of the bypass path while reset is held.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign requests[gi] = {write_enabled[gi] & reset_n,
                             MAX_ADDR_WIDTH'(write_address[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                             MAX_STRB_WIDTH'(write_strobe[gi*STRB_WIDTH +: STRB_WIDTH]),
                             MAX_DATA_WIDTH'(write_data[gi*DATA_WIDTH +: DATA_WIDTH])};
    end
  endgenerate

  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            regs_reg[gi]    <= '0;
            pending_reg[gi] <= 1'b0;
          end else begin
            regs_reg[gi]    <= '0;
            pending_reg[gi] <= 1'b0;
          end
        end
      end else begin : g_live
        logic [DATA_WIDTH-1:0] value_next;
        logic                  hit;
        logic                  pending_next;

        register_file_write_merge #(
          .DATA_WIDTH (DATA_WIDTH),
          .ADDR_WIDTH (ADDR_WIDTH)
        ) u_merge (
          .index      (ADDR_WIDTH'(gi)),
          .stored     (regs_reg[gi]),
          .port0      (requests[0]),
          .port1      (requests[1]),
          .next_value (value_next),
          .hit        (hit)
        );

        // A new producer marked this cycle outranks a writeback of the old one.
        assign pending_next = (pending_set_enabled && pending_set_address == ADDR_WIDTH'(gi))
                            || (pending_reg[gi] && !hit);

        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            regs_reg[gi]    <= '0;
            pending_reg[gi] <= 1'b0;
          end else begin
            regs_reg[gi]    <= value_next;
            pending_reg[gi] <= pending_next;
          end
        end
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < READ_PORTS; gi++) begin : g_read
      logic [ADDR_WIDTH-1:0] address;
      logic [DATA_WIDTH-1:0] value;

      assign address = read_address[gi*ADDR_WIDTH +: ADDR_WIDTH];

      if (BYPASS != 0) begin : g_bypass
        logic unused_hit;
        register_file_write_merge #(
          .DATA_WIDTH (DATA_WIDTH),
          .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bypass (
          .index      (address),
          .stored     (regs_reg[address]),
          .port0      (requests[0]),
          .port1      (requests[1]),
          .next_value (value),
          .hit        (unused_hit)
        );
      end else begin : g_stored
        assign value = regs_reg[address];
      end

      assign read_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        (ZERO_REG != 0 && address == '0) ? '0 : value;
      assign read_pending[gi] = pending_reg[address];
    end
  endgenerate

endmodule

// File: tb/tb_multi_port_register_file.sv
// Randomised bench for the register file: a bypassing zero-register instance and a
// plain stored-read instance share stimulus and are compared against array models.
module tb_multi_port_register_file;

  localparam int DW = 32;
  localparam int RC = 32;
  localparam int RP = 2;
  localparam int AW = 5;
  localparam int SW = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [RP*AW-1:0] read_address;
  logic [RP*DW-1:0] read_data_a;
  logic [RP*DW-1:0] read_data_b;
  logic [RP-1:0]    read_pending_a;
  logic [RP-1:0]    read_pending_b;
  logic [1:0]       write_enabled;
  logic [2*AW-1:0]  write_address;
  logic [2*SW-1:0]  write_strobe;
  logic [2*DW-1:0]  write_data;
  logic             pending_set_enabled;
  logic [AW-1:0]    pending_set_address;

  always #5 clock = ~clock;

  multi_port_register_file #(
    .DATA_WIDTH (DW), .REG_COUNT (RC), .READ_PORTS (RP), .ZERO_REG (1), .BYPASS (1)
  ) dut_a (
    .clock (clock), .reset_n (reset_n),
    .read_address (read_address), .read_data (read_data_a), .read_pending (read_pending_a),
    .write_enabled (write_enabled), .write_address (write_address),
    .write_strobe (write_strobe), .write_data (write_data),
    .pending_set_enabled (pending_set_enabled), .pending_set_address (pending_set_address)
  );

  multi_port_register_file #(
    .DATA_WIDTH (DW), .REG_COUNT (RC), .READ_PORTS (RP), .ZERO_REG (0), .BYPASS (0)
  ) dut_b (
    .clock (clock), .reset_n (reset_n),
    .read_address (read_address), .read_data (read_data_b), .read_pending (read_pending_b),
    .write_enabled (write_enabled), .write_address (write_address),
    .write_strobe (write_strobe), .write_data (write_data),
    .pending_set_enabled (pending_set_enabled), .pending_set_address (pending_set_address)
  );

  logic [DW-1:0] mem_a  [RC];
  logic [DW-1:0] mem_b  [RC];
  logic          pend_a [RC];
  logic          pend_b [RC];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_value(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_a(input int q);
    return read_data_a[q*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] data_b(input int q);
    return read_data_b[q*DW +: DW];
  endfunction

  // Value a register holds after this cycle's writes: port 0 lanes, then port 1 lanes.
  function automatic logic [DW-1:0] after_writes(input int r, input logic [DW-1:0] cur);
    logic [DW-1:0] v;
    v = cur;
    for (int p = 0; p < 2; p++) begin
      if (write_enabled[p] && int'(write_address[p*AW +: AW]) == r) begin
        for (int b = 0; b < SW; b++) begin
          if (write_strobe[p*SW + b]) v[b*8 +: 8] = write_data[p*DW + b*8 +: 8];
        end
      end
    end
    return v;
  endfunction

  function automatic logic next_pending(input int r, input logic cur);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (write_enabled[p] && int'(write_address[p*AW +: AW]) == r) hit = 1'b1;
    end
    if (pending_set_enabled && int'(pending_set_address) == r) return 1'b1;
    return hit ? 1'b0 : cur;
  endfunction

  task automatic clear_models();
    for (int r = 0; r < RC; r++) begin
      mem_a[r] = '0; mem_b[r] = '0; pend_a[r] = 1'b0; pend_b[r] = 1'b0;
    end
  endtask

  task automatic update_model();
    for (int r = 0; r < RC; r++) begin
      mem_b[r]  = after_writes(r, mem_b[r]);
      pend_b[r] = next_pending(r, pend_b[r]);
      if (r != 0) begin
        mem_a[r]  = after_writes(r, mem_a[r]);
        pend_a[r] = next_pending(r, pend_a[r]);
      end
    end
  endtask

  task automatic check_reads();
    int a;
    logic [DW-1:0] exp_a;
    for (int q = 0; q < RP; q++) begin
      a = int'(read_address[q*AW +: AW]);
      exp_a = (a == 0 || !reset_n) ? '0 : after_writes(a, mem_a[a]);
      check_value($sformatf("a.p%0d.data r%0d", q, a), data_a(q), exp_a);
      check_value($sformatf("b.p%0d.data r%0d", q, a), data_b(q), mem_b[a]);
      check_value($sformatf("a.p%0d.pend r%0d", q, a), DW'(read_pending_a[q]), DW'(pend_a[a]));
      check_value($sformatf("b.p%0d.pend r%0d", q, a), DW'(read_pending_b[q]), DW'(pend_b[a]));
    end
  endtask

  task automatic step();
    check_reads();
    @(posedge clock);
    if (reset_n) update_model();
    @(negedge clock);
  endtask

  task automatic idle();
    write_enabled = '0; write_address = '0; write_strobe = '0; write_data = '0;
    pending_set_enabled = 1'b0; pending_set_address = '0;
  endtask

  task automatic set_write(input int p, input logic [AW-1:0] a, input logic [SW-1:0] s,
                           input logic [DW-1:0] d);
    write_enabled[p] = 1'b1;
    write_address[p*AW +: AW] = a;
    write_strobe[p*SW +: SW]  = s;
    write_data[p*DW +: DW]    = d;
  endtask

  task automatic set_pending(input logic [AW-1:0] a);
    pending_set_enabled = 1'b1;
    pending_set_address = a;
  endtask

  task automatic set_reads(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    read_address = {a1, a0};
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, RC-1)) : AW'($urandom_range(0, 5));
  endfunction

  initial begin
    idle();
    read_address = '0;
    clear_models();
    @(negedge clock);

    // Writes and a pending set presented while reset is held
    set_write(0, 5'd5, 4'hf, 32'hdeadbeef);
    set_write(1, 5'd5, 4'hf, 32'hcafef00d);
    set_pending(5'd5);
    set_reads(5'd5, 5'd5);
    #1;
    check_value("reset_data_a", data_a(0), 32'h0);
    check_value("reset_pend_a", DW'(read_pending_a[0]), 32'h0);
    step();
    #1; step();
    reset_n = 1'b1;
    idle(); set_reads(5'd5, 5'd1);
    #1;
    check_value("r5_after_reset_a", data_a(0), 32'h0);
    check_value("r5_after_reset_b", data_b(0), 32'h0);
    step();

    // Basic write, bypass versus stored read
    idle(); set_write(0, 5'd1, 4'hf, 32'h1111ffff); set_reads(5'd1, 5'd2);
    #1;
    check_value("r1_bypass_same_cycle", data_a(0), 32'h1111ffff);
    check_value("r1_stored_same_cycle", data_b(0), 32'h0);
    step();
    idle(); set_reads(5'd1, 5'd2);
    #1;
    check_value("r1_stored_next_cycle", data_b(0), 32'h1111ffff);
    check_value("r2_untouched", data_a(1), 32'h0);
    step();

    // Byte strobes
    idle(); set_write(0, 5'd3, 4'hf, 32'hAABBCCDD);
    #1; step();
    idle(); set_write(1, 5'd3, 4'b0101, 32'h11223344); set_reads(5'd3, 5'd3);
    #1;
    check_value("r3_strobe_bypass", data_a(0), 32'hAA22CC44);
    step();
    idle(); set_reads(5'd3, 5'd3);
    #1;
    check_value("r3_strobe_stored", data_b(1), 32'hAA22CC44);
    step();

    // Both ports on one register, port 1 owns the lanes it strobes
    idle();
    set_write(0, 5'd16, 4'hf, 32'h0000ffff);
    set_write(1, 5'd16, 4'b0011, 32'h2222eeee);
    set_reads(5'd16, 5'd16);
    #1;
    check_value("r16_dual_bypass", data_a(0), 32'h0000eeee);
    step();
    idle(); set_reads(5'd16, 5'd16);
    #1;
    check_value("r16_dual_stored", data_b(0), 32'h0000eeee);
    step();

    // Zero register
    idle(); set_write(0, 5'd0, 4'hf, 32'hffffffff); set_pending(5'd0); set_reads(5'd0, 5'd0);
    #1;
    check_value("r0_bypass", data_a(0), 32'h0);
    step();
    idle(); set_reads(5'd0, 5'd0);
    #1;
    check_value("r0_data", data_a(0), 32'h0);
    check_value("r0_pending", DW'(read_pending_a[1]), 32'h0);
    step();

    // Scoreboard set, set-beats-clear, later clear
    idle(); set_pending(5'd20); set_reads(5'd20, 5'd20);
    #1;
    check_value("r20_pend_not_yet", DW'(read_pending_a[0]), 32'h0);
    step();
    idle(); set_reads(5'd20, 5'd20);
    #1;
    check_value("r20_pend_set", DW'(read_pending_a[0]), 32'h1);
    step();
    idle(); set_write(0, 5'd20, 4'h0, 32'h12345678); set_pending(5'd20);
    #1; step();
    idle(); set_reads(5'd20, 5'd20);
    #1;
    check_value("r20_set_wins", DW'(read_pending_a[0]), 32'h1);
    check_value("r20_zero_strobe_data", data_a(0), 32'h0);
    step();
    idle(); set_write(1, 5'd20, 4'h0, 32'h0);
    #1;
    check_value("r20_clear_not_yet", DW'(read_pending_a[1]), 32'h1);
    step();
    idle(); set_reads(5'd20, 5'd20);
    #1;
    check_value("r20_cleared", DW'(read_pending_a[1]), 32'h0);
    step();

    // Reset asserted mid-operation drops the cycle's write
    idle(); set_write(0, 5'd7, 4'hf, 32'h77777777); set_reads(5'd7, 5'd3);
    #1; step();
    idle(); set_write(0, 5'd7, 4'hf, 32'h88888888);
    reset_n = 1'b0;
    clear_models();
    #1;
    check_value("midreset_r7", data_a(0), 32'h0);
    check_value("midreset_r3", data_b(1), 32'h0);
    step();
    reset_n = 1'b1;
    idle(); set_reads(5'd7, 5'd16);
    #1;
    check_value("after_midreset_r7", data_b(0), 32'h0);
    step();

    // Random traffic with collisions on a few hot registers
    for (int n = 0; n < 500; n++) begin
      reset_n = ($urandom_range(0, 79) != 0);
      if (!reset_n) clear_models();
      for (int p = 0; p < 2; p++) begin
        write_enabled[p]          = ($urandom_range(0, 2) != 0);
        write_address[p*AW +: AW] = rand_addr();
        write_strobe[p*SW +: SW]  = SW'($urandom);
        write_data[p*DW +: DW]    = $urandom;
      end
      pending_set_enabled = ($urandom_range(0, 1) != 0);
      pending_set_address = rand_addr();
      set_reads(rand_addr(), rand_addr());
      #1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
